display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display. It drives the 2-bit digit select and the 4-bit BCD code into the existing anode/segment decoder. A prescaler paces the digit rotation. A double-buffered load handshake means new 4-digit values appear only at frame boundaries, so the display never tears. It sits between the application logic (counters/calculators producing BCD) and the decoder.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is held (dwell); legal range 2..2^20; sim benches use 4
DASH_CODE, 4'd10, code sent to the decoder for an invalid frame (decoder shows a dash)

Ports:
clk  input  1  system clock, single domain
rst  input  1  synchronous, active-high reset
value_in  input  16  four BCD nibbles; [15:12] leftmost digit, [3:0] rightmost
load  input  1  one-cycle request to capture value_in
busy  output  1  high while a captured value awaits the frame boundary
load_ack  output  1  one-cycle pulse: captured value now displayed
frame_tick  output  1  one-cycle pulse at the start of every frame
digit_sel  output  2  to decoder en; 0 = leftmost anode ... 3 = rightmost
bcd_out  output  4  to decoder bcd

Behaviour:
- Reset (sync, rst high at posedge): prescaler=0, digit_sel=0, active=16'h0000, err=0, pending=0, busy=0, load_ack=0, frame_tick=0. bcd_out=0, displaying "0000". rst overrides all other inputs, including an in-flight load; a pending value is discarded.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps. The terminal count (TC) is prescaler==REFRESH_DIV-1.
- On TC, digit_sel increments mod 4 (3 wraps to 0). Each digit is held for exactly REFRESH_DIV cycles. A frame is 4*REFRESH_DIV cycles.
- Frame boundary (FB) = TC while digit_sel==3.
- bcd_out = DASH_CODE if err, else the active nibble selected by digit_sel (0->[15:12], 1->[11:8], 2->[7:4], 3->[3:0]). bcd_out is combinational from registers, so it changes in the same cycle as digit_sel.
- Handshake FSM, two states:
  - IDLE (busy=0).
  - PEND (busy=1).
  - IDLE + load: pending<=value_in; go to PEND.
  - PEND + load without FB: pending<=value_in; the last load wins; stay in PEND.
  - PEND + FB: active<=pending; err<=(any pending nibble >9); go to IDLE; load_ack<=1 for one cycle.
  - PEND + load + FB in the same cycle: active<=old pending; pending<=new value_in; stay in PEND; load_ack pulses.
  - IDLE + load + FB in the same cycle: capture only. The transfer happens at the next FB, never in the same cycle.
- load_ack and frame_tick are registered. Both are high during the first cycle of digit_sel==0 after FB. frame_tick fires on every FB; load_ack fires only on a transfer.
- Latency: a load is displayed between 1 and 4*REFRESH_DIV cycles after it is captured.
- An invalid value forces all four digits to DASH_CODE for the whole frame. The next valid transfer clears err.
- value_in is sampled only on load cycles.

Test Plan:
1. Reset, REFRESH_DIV=4, no load -> digit_sel steps 0,1,2,3 every 4 cycles; bcd_out=0 throughout; frame_tick pulses every 16 cycles; busy=0.
2. load with value_in=16'h1234 at cycle 5 -> busy=1 until the FB at cycle 15; cycle 16: load_ack=1, busy=0; bcd_out sequence 1,2,3,4 matches digit_sel 0..3.
3. load 16'h1111, then load 16'h5678 two cycles later, both before FB -> a single load_ack; the display shows 5,6,7,8; 1111 never appears.
4. Active value 16'h1234; load 16'h9999 on the exact FB cycle -> the next frame still shows 1234 with no load_ack; 9999 appears after the following FB with load_ack.
5. load 16'h12A4 -> after the transfer, bcd_out=10 for all four digits; then load 16'h0042 -> the next frame shows 0,0,4,2.
6. rst asserted mid-frame while busy=1 -> the next cycle shows all registers at reset values; the pending value is never displayed; no load_ack.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// A prescaler holds each digit for REFRESH_DIV cycles. digit_sel rotates
// 0..3 (leftmost..rightmost), and bcd_out carries the matching BCD nibble
// to the downstream anode/segment decoder.
// New 4-digit values are double buffered. A load captures value_in into
// a pending buffer. The pending value becomes the active value only at a
// frame boundary, so a frame is never drawn from two different values.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   value_in   four BCD nibbles, [15:12] leftmost digit
//   load       one-cycle capture request for value_in
//   busy       high while a captured value waits for the frame boundary
//   load_ack   one-cycle pulse when the captured value becomes visible
//   frame_tick one-cycle pulse in the first cycle of every frame
//   digit_sel  digit being driven, 0 = leftmost
//   bcd_out    code for the selected digit (DASH_CODE if the frame is invalid)
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter logic [3:0]  DASH_CODE   = 4'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic        busy,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [1:0]  digit_sel,
  output logic [3:0]  bcd_out
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TC_VAL = PW'(REFRESH_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          err;
  logic          tc;
  logic          fb;
  logic [3:0]    nibble;

  // Returns 1 when any of the four nibbles is not a decimal digit.
  function automatic logic bcd_invalid(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  assign tc = (prescaler == TC_VAL);
  // The frame boundary is the last cycle of the rightmost digit.
  assign fb = tc && (digit_sel == 2'd3);

  // Dwell prescaler and digit rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      digit_sel <= 2'd0;
    end else if (tc) begin
      prescaler <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
      digit_sel <= digit_sel;
    end
  end

  // Load handshake FSM with double buffer and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      active     <= 16'h0000;
      pending    <= 16'h0000;
      err        <= 1'b0;
      busy       <= 1'b0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= fb;
      load_ack   <= 1'b0;
      case (state)
        IDLE: begin
          // A load coinciding with the boundary is only captured here;
          // the transfer waits for the following boundary.
          if (load) begin
            pending <= value_in;
            state   <= PEND;
            busy    <= 1'b1;
          end else begin
            state   <= IDLE;
            busy    <= 1'b0;
          end
        end
        PEND: begin
          if (fb) begin
            active   <= pending;
            err      <= bcd_invalid(pending);
            load_ack <= 1'b1;
            // A load on the boundary cycle refills the buffer just emptied.
            if (load) begin
              pending <= value_in;
              state   <= PEND;
              busy    <= 1'b1;
            end else begin
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end else if (load) begin
            pending <= value_in;
            state   <= PEND;
            busy    <= 1'b1;
          end else begin
            state   <= PEND;
            busy    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Digit nibble select; an invalid frame shows a dash on every digit.
  always_comb begin
    nibble = 4'd0;
    case (digit_sel)
      2'd0:    nibble = active[15:12];
      2'd1:    nibble = active[11:8];
      2'd2:    nibble = active[7:4];
      2'd3:    nibble = active[3:0];
      default: nibble = 4'd0;
    endcase
    if (err) begin
      bcd_out = DASH_CODE;
    end else begin
      bcd_out = nibble;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic        busy;
  logic        load_ack;
  logic        frame_tick;
  logic [1:0]  digit_sel;
  logic [3:0]  bcd_out;

  int total;
  int bad;
  int cyc;

  typedef struct {
    int          c;
    logic        ld;
    logic [15:0] val;
    logic [1:0]  sel;
    logic [3:0]  bcd;
    logic        bsy;
    logic        ack;
    logic        tick;
  } vec_t;

  vec_t vq[$];

  display_scan_ctrl #(
    .REFRESH_DIV(4),
    .DASH_CODE(4'd10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value_in(value_in),
    .load(load),
    .busy(busy),
    .load_ack(load_ack),
    .frame_tick(frame_tick),
    .digit_sel(digit_sel),
    .bcd_out(bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add(input int c, input logic ld, input logic [15:0] val, input logic [1:0] sel,
                     input logic [3:0] bcd, input logic bsy, input logic ack, input logic tick);
    vec_t v;
    v.c = c; v.ld = ld; v.val = val; v.sel = sel; v.bcd = bcd;
    v.bsy = bsy; v.ack = ack; v.tick = tick;
    vq.push_back(v);
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rst = 1'b1;
    load = 1'b0;
    value_in = 16'h0000;

    //   cyc  ld    value     sel   bcd   busy  ack   tick
    // idle scan after reset
    add(0,   1'b0, 16'h0000, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(3,   1'b0, 16'h0000, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(4,   1'b0, 16'h0000, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    add(8,   1'b0, 16'h0000, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    add(12,  1'b0, 16'h0000, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    add(15,  1'b0, 16'h0000, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    add(16,  1'b0, 16'h0000, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    add(17,  1'b0, 16'h0000, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    // single load of 1234
    add(21,  1'b1, 16'h1234, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    add(22,  1'b0, 16'h0000, 2'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    add(31,  1'b0, 16'h0000, 2'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    add(32,  1'b0, 16'h0000, 2'd0, 4'd1, 1'b0, 1'b1, 1'b1);
    add(33,  1'b0, 16'h0000, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    add(36,  1'b0, 16'h0000, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0);
    add(40,  1'b0, 16'h0000, 2'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    add(44,  1'b0, 16'h0000, 2'd3, 4'd4, 1'b0, 1'b0, 1'b0);
    // two loads before one boundary: last wins, one ack
    add(50,  1'b1, 16'h1111, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    add(52,  1'b1, 16'h5678, 2'd1, 4'd2, 1'b1, 1'b0, 1'b0);
    add(53,  1'b0, 16'h0000, 2'd1, 4'd2, 1'b1, 1'b0, 1'b0);
    add(63,  1'b0, 16'h0000, 2'd3, 4'd4, 1'b1, 1'b0, 1'b0);
    add(64,  1'b0, 16'h0000, 2'd0, 4'd5, 1'b0, 1'b1, 1'b1);
    add(65,  1'b0, 16'h0000, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0);
    add(68,  1'b0, 16'h0000, 2'd1, 4'd6, 1'b0, 1'b0, 1'b0);
    add(72,  1'b0, 16'h0000, 2'd2, 4'd7, 1'b0, 1'b0, 1'b0);
    add(76,  1'b0, 16'h0000, 2'd3, 4'd8, 1'b0, 1'b0, 1'b0);
    add(80,  1'b0, 16'h0000, 2'd0, 4'd5, 1'b0, 1'b0, 1'b1);
    // load on the boundary while idle: capture only, transfer one frame later
    add(95,  1'b1, 16'h9999, 2'd3, 4'd8, 1'b0, 1'b0, 1'b0);
    add(96,  1'b0, 16'h0000, 2'd0, 4'd5, 1'b1, 1'b0, 1'b1);
    add(100, 1'b0, 16'h0000, 2'd1, 4'd6, 1'b1, 1'b0, 1'b0);
    add(111, 1'b0, 16'h0000, 2'd3, 4'd8, 1'b1, 1'b0, 1'b0);
    add(112, 1'b0, 16'h0000, 2'd0, 4'd9, 1'b0, 1'b1, 1'b1);
    // load on the boundary while pending: transfer old, keep new pending
    add(120, 1'b1, 16'h1111, 2'd2, 4'd9, 1'b0, 1'b0, 1'b0);
    add(127, 1'b1, 16'h4321, 2'd3, 4'd9, 1'b1, 1'b0, 1'b0);
    add(128, 1'b0, 16'h0000, 2'd0, 4'd1, 1'b1, 1'b1, 1'b1);
    add(132, 1'b0, 16'h0000, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    add(143, 1'b0, 16'h0000, 2'd3, 4'd1, 1'b1, 1'b0, 1'b0);
    add(144, 1'b0, 16'h0000, 2'd0, 4'd4, 1'b0, 1'b1, 1'b1);
    // invalid value shows dashes, next valid value clears them
    add(146, 1'b1, 16'h12A4, 2'd0, 4'd4, 1'b0, 1'b0, 1'b0);
    add(148, 1'b0, 16'h0000, 2'd1, 4'd3, 1'b1, 1'b0, 1'b0);
    add(159, 1'b0, 16'h0000, 2'd3, 4'd1, 1'b1, 1'b0, 1'b0);
    add(160, 1'b0, 16'h0000, 2'd0, 4'd10, 1'b0, 1'b1, 1'b1);
    add(164, 1'b0, 16'h0000, 2'd1, 4'd10, 1'b0, 1'b0, 1'b0);
    add(168, 1'b0, 16'h0000, 2'd2, 4'd10, 1'b0, 1'b0, 1'b0);
    add(170, 1'b1, 16'h0042, 2'd2, 4'd10, 1'b0, 1'b0, 1'b0);
    add(172, 1'b0, 16'h0000, 2'd3, 4'd10, 1'b1, 1'b0, 1'b0);
    add(175, 1'b0, 16'h0000, 2'd3, 4'd10, 1'b1, 1'b0, 1'b0);
    add(176, 1'b0, 16'h0000, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    add(180, 1'b0, 16'h0000, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    add(184, 1'b0, 16'h0000, 2'd2, 4'd4, 1'b0, 1'b0, 1'b0);
    add(188, 1'b0, 16'h0000, 2'd3, 4'd2, 1'b0, 1'b0, 1'b0);
    add(192, 1'b0, 16'h0000, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    // pending load that the reset below must discard
    add(193, 1'b1, 16'h7777, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(194, 1'b0, 16'h0000, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    foreach (vq[i]) begin
      while (cyc < vq[i].c) step();
      load = vq[i].ld;
      value_in = vq[i].val;
      check("digit_sel", 16'(digit_sel), 16'(vq[i].sel));
      check("bcd_out", 16'(bcd_out), 16'(vq[i].bcd));
      check("busy", 16'(busy), 16'(vq[i].bsy));
      check("load_ack", 16'(load_ack), 16'(vq[i].ack));
      check("frame_tick", 16'(frame_tick), 16'(vq[i].tick));
      step();
      load = 1'b0;
      value_in = 16'h0000;
    end

    // Reset mid-frame while busy, with a competing load in the reset cycle.
    while (cyc < 197) step();
    check("pre_rst_busy", 16'(busy), 16'd1);
    check("pre_rst_sel", 16'(digit_sel), 16'd1);
    rst = 1'b1;
    load = 1'b1;
    value_in = 16'h8888;
    step();
    rst = 1'b0;
    load = 1'b0;
    value_in = 16'h0000;
    cyc = 0;
    check("rst_sel", 16'(digit_sel), 16'd0);
    check("rst_bcd", 16'(bcd_out), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_ack", 16'(load_ack), 16'd0);
    check("rst_tick", 16'(frame_tick), 16'd0);
    for (int k = 1; k <= 20; k++) begin
      step();
      check("post_rst_sel", 16'(digit_sel), 16'((k / 4) % 4));
      check("post_rst_bcd", 16'(bcd_out), 16'd0);
      check("post_rst_busy", 16'(busy), 16'd0);
      check("post_rst_ack", 16'(load_ack), 16'd0);
      check("post_rst_tick", 16'(frame_tick), (k == 16) ? 16'd1 : 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
